// File: rtl/mailbox_apb_bridge.sv
// APB3 slave fronting one side of the mailbox interrupt register block.
// Define MAILBOX_BRIDGE_RMW_EN to enable the SET/CLR read-modify-write aliases.
module mailbox_apb_bridge #(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              mb_wr,
  output logic              mb_rd,
  output logic [5:0]        mb_wdata,
  input  logic [5:0]        mb_rdata,
  input  logic              mb_rvalid,
  input  logic              irq_mp,
  input  logic              irq_ack
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    RESP
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;
  logic        r_mb_wr;
  logic        r_mb_rd;
  logic [5:0]  r_mb_wdata;
`ifdef MAILBOX_BRIDGE_RMW_EN
  logic [5:0]  r_mask;
  logic        r_is_set;
  logic        r_is_rmw;
`endif

  logic       w_req;
  logic [1:0] w_off;
  logic       w_unused;

  assign w_req    = psel & penable;
  assign w_off    = paddr[3:2];
  assign w_unused = ^{pwdata[31:6], paddr};

  // Response/pulse outputs default low every cycle; they are raised only on the
  // transition into the state where they must be visible, so each lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_prdata   <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_mb_wr    <= 1'b0;
      r_mb_rd    <= 1'b0;
      r_mb_wdata <= '0;
`ifdef MAILBOX_BRIDGE_RMW_EN
      r_mask     <= '0;
      r_is_set   <= 1'b0;
      r_is_rmw   <= 1'b0;
`endif
    end else begin
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_mb_wr   <= 1'b0;
      r_mb_rd   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            case (w_off)
              2'd0: begin
`ifdef MAILBOX_BRIDGE_RMW_EN
                r_is_rmw <= 1'b0;
`endif
                if (pwrite) begin
                  r_mb_wdata <= pwdata[5:0];
                  r_mb_wr    <= 1'b1;
                  r_state    <= WR;
                end else begin
                  r_mb_rd <= 1'b1;
                  r_state <= RD;
                end
              end
              2'd1: begin
                r_pready <= 1'b1;
                r_state  <= RESP;
                if (pwrite) begin
                  r_pslverr <= 1'b1;
                end else begin
                  r_prdata <= {30'b0, irq_ack, irq_mp};
                end
              end
              default: begin
`ifdef MAILBOX_BRIDGE_RMW_EN
                if (pwrite) begin
                  r_mask   <= pwdata[5:0];
                  r_is_set <= ~paddr[2];
                  r_is_rmw <= 1'b1;
                  r_mb_rd  <= 1'b1;
                  r_state  <= RD;
                end else begin
                  r_pready  <= 1'b1;
                  r_pslverr <= 1'b1;
                  r_state   <= RESP;
                end
`else
                r_pready  <= 1'b1;
                r_pslverr <= 1'b1;
                r_state   <= RESP;
`endif
              end
            endcase
          end
        end
        RD: begin
          r_cnt   <= '0;
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mb_rvalid) begin
`ifdef MAILBOX_BRIDGE_RMW_EN
            if (r_is_rmw) begin
              r_mb_wdata <= r_is_set ? (mb_rdata | r_mask) : (mb_rdata & ~r_mask);
              r_mb_wr    <= 1'b1;
              r_state    <= WR;
            end else begin
              r_prdata <= {26'b0, mb_rdata};
              r_pready <= 1'b1;
              r_state  <= RESP;
            end
`else
            r_prdata <= {26'b0, mb_rdata};
            r_pready <= 1'b1;
            r_state  <= RESP;
`endif
          end else if (r_cnt == LP_TO_LAST) begin
            // Response lands TIMEOUT_CYCLES after the first wait cycle.
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        WR: begin
          r_pready <= 1'b1;
          r_state  <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign prdata   = r_prdata;
  assign pready   = r_pready;
  assign pslverr  = r_pslverr;
  assign mb_wr    = r_mb_wr;
  assign mb_rd    = r_mb_rd;
  assign mb_wdata = r_mb_wdata;

endmodule

// File: doc/mailbox_apb_bridge.md
# mailbox_apb_bridge

APB3 slave that fronts one side (A or B) of the mailbox interrupt register block. It turns processor APB accesses into the mailbox's single-cycle `wr`/`rd` pulses and waits for its `rvalid` read response. It also exposes the two interrupt lines as a read-only status word and, optionally, atomic set/clear aliases built as read-modify-write sequences. One instance per mailbox side; outputs connect directly to that side's `wr_x`/`rd_x`/`wdata_x` inputs.

## Interface
- `ADDR_W`, 4: APB address width; only `paddr[3:2]` is decoded.
- `TIMEOUT_CYCLES`, 15: maximum cycles to wait for `mb_rvalid` after `mb_rd`; range 1-255.

Ports:
- `clk`  in  1  single clock, shared with the mailbox block.
- `reset`  in  1  synchronous, active-high reset.
- `psel`  in  1  APB select.
- `penable`  in  1  APB enable.
- `pwrite`  in  1  APB write.
- `paddr`  in  ADDR_W  APB address.
- `pwdata`  in  32  APB write data; only bits [5:0] are used.
- `prdata`  out  32  APB read data.
- `pready`  out  1  APB ready, one-cycle pulse.
- `pslverr`  out  1  APB error, valid with `pready`.
- `mb_wr`  out  1  mailbox write pulse.
- `mb_rd`  out  1  mailbox read pulse.
- `mb_wdata`  out  6  mailbox write data.
- `mb_rdata`  in  6  mailbox read data.
- `mb_rvalid`  in  1  mailbox read data valid, one cycle.
- `irq_mp`  in  1  this side's message-pending IRQ.
- `irq_ack`  in  1  this side's acknowledge IRQ.

## Operation
- Address map (`paddr[3:2]`):
  - 0 `CTRL`: read/write, maps to the mailbox's 6-bit register.
  - 1 `STATUS`: read-only, returns `{30'b0, irq_ack, irq_mp}`.
  - 2 `SET`: write-only, write-1-to-set.
  - 3 `CLR`: write-only, write-1-to-clear.
- Error responses (`pslverr`=1, `prdata`=0, no side effect on the mailbox):
  - write to `STATUS`;
  - read of `SET` or `CLR`;
  - `mb_rvalid` timeout.
- FSM states: `IDLE`, `RD`, `RD_WAIT`, `WR`, `RESP`.
- `IDLE`: waits for `psel & penable`, then branches:
  - `CTRL` write -> `WR`, with `mb_wdata = pwdata[5:0]`.
  - `CTRL` read or `SET`/`CLR` write -> `RD`.
  - `STATUS` read or any error case -> `RESP`.
- `RD`: `mb_rd` high for exactly one cycle; clears the timeout counter; -> `RD_WAIT`.
- `RD_WAIT`: counter increments each cycle.
  - On `mb_rvalid`, capture `mb_rdata`.
    - Plain read -> `RESP`.
    - `SET` -> `WR` with `mb_wdata = mb_rdata | pwdata[5:0]`.
    - `CLR` -> `WR` with `mb_wdata = mb_rdata & ~pwdata[5:0]`.
  - When the counter reaches `TIMEOUT_CYCLES` without `mb_rvalid` -> `RESP` with error. A `mb_rvalid` arriving later is ignored.
- `WR`: `mb_wr` high for exactly one cycle -> `RESP`.
- `RESP`: `pready` high for one cycle with `prdata`/`pslverr` valid -> `IDLE`.
- `mb_wr` and `mb_rd` are never asserted in the same cycle.
- `mb_rvalid` seen in any state other than `RD_WAIT` is ignored.
- If `psel` drops mid-sequence (protocol violation): the mailbox-side sequence still completes, `pready` is still pulsed, then the FSM returns to `IDLE`.
- `prdata` is 0 whenever `pready` is low.

## Timing
- T = first cycle with `psel & penable` while in `IDLE`. All outputs are registered.
- `CTRL` write: `mb_wr` at T+1, `pready` at T+2.
- `CTRL` read: `mb_rd` at T+1. With `mb_rvalid` at T+2 (nominal mailbox latency), `pready` and `prdata` at T+3.
- `SET`/`CLR`: `mb_rd` at T+1, `mb_rvalid` at T+2, `mb_wr` at T+3, `pready` at T+4.
- `STATUS` read or error decode: `pready` at T+1. `irq_*` are sampled at T.
- Timeout: `pready` with `pslverr` at T+2+`TIMEOUT_CYCLES`.
- A new transfer is accepted no earlier than the cycle after `pready`.
- Reset: all outputs 0 (`prdata`, `pready`, `pslverr`, `mb_wr`, `mb_rd`, `mb_wdata`); FSM -> `IDLE`; counter cleared.
- Reset asserted mid-sequence aborts it: no `mb_wr` is issued after a reset cycle, and no `pready` is given for the aborted transfer.

## Configuration
- `MAILBOX_BRIDGE_RMW_EN` defined: `SET`/`CLR` aliases behave as described above.
- Undefined: no RMW path exists; any access to offsets 2 or 3 gets the error response at T+1, and `mb_rd`/`mb_wr` stay low.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0 and no `mb_wr`/`mb_rd` pulses.
- `CTRL` write `pwdata`=0x2A -> `mb_wr` at T+1 with `mb_wdata`=0x2A; `pready`=1, `pslverr`=0 at T+2.
- `CTRL` read, mailbox returns 0x15 at T+2 -> `prdata`=0x15 with `pready` at T+3.
- `SET` `pwdata`=0x06 with mailbox 0x21 -> `mb_wr` at T+3 with 0x27. Then `CLR` `pwdata`=0x01 with mailbox 0x27 -> `mb_wr` with 0x26. Without the macro, both accesses -> `pslverr` at T+1 and no mailbox pulses.
- `STATUS` read with `irq_mp`=1, `irq_ack`=0 -> `prdata`=0x1 at T+1. Write to `STATUS` -> `pslverr`=1 and no `mb_wr`.
- Hold `mb_rvalid` low after `mb_rd` with default `TIMEOUT_CYCLES`=15 -> `pslverr`=1, `prdata`=0 at T+17. Separately, reset asserted in `RD_WAIT` -> no `pready` and no `mb_wr` is ever issued for that transfer.
